fifo_ring: RTL

- Parametrised successor to the two-entry ping-pong FIFO: a WIDTH-bit, DEPTH-entry circular-buffer FIFO.
- Keeps the same enq/deq/first method interface with ENA/RDY guards.
- Adds concurrent enqueue and dequeue in one cycle, plus an occupancy count.
- Sits between producer and consumer modules as the standard elastic buffer in generated designs.

---
 rtl/fifo_ring.sv | 94 +++++++++
 1 files changed

// File: rtl/fifo_ring.sv
// Circular-buffer FIFO, WIDTH bits x DEPTH entries, with enq/deq/first guards and occupancy count.
// Optional synchronous clear port pair enabled by defining FIFO_RING_CLEAR_EN.
module fifo_ring #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     in_enq__ENA,
  input  logic [WIDTH-1:0]         in_enq_v,
  output logic                     in_enq__RDY,
  input  logic                     out_deq__ENA,
  output logic                     out_deq__RDY,
  output logic [WIDTH-1:0]         out_first,
  output logic                     out_first__RDY,
`ifdef FIFO_RING_CLEAR_EN
  input  logic                     in_clear__ENA,
  output logic                     in_clear__RDY,
`endif
  output logic [$clog2(DEPTH):0]   out_count
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]  storage_q [DEPTH];
  logic [WIDTH-1:0]  storage_d [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              enq_fire, deq_fire, clear_fire;

  // Guards depend only on registered count, so no ENA->RDY path exists.
  assign in_enq__RDY    = (count_q != FULL_CNT);
  assign out_deq__RDY   = (count_q != '0);
  assign out_first__RDY = (count_q != '0);
  assign out_first      = storage_q[rd_ptr_q];
  assign out_count      = count_q;

  assign enq_fire = in_enq__ENA && in_enq__RDY;
  assign deq_fire = out_deq__ENA && out_deq__RDY;

`ifdef FIFO_RING_CLEAR_EN
  assign in_clear__RDY = 1'b1;
  assign clear_fire    = in_clear__ENA;
`else
  assign clear_fire    = 1'b0;
`endif

  always_comb begin
    storage_d = storage_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (clear_fire) begin
      // Clear wins over enq/deq; concurrent enq data is dropped, storage kept.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_fire) begin
        storage_d[wr_ptr_q] = in_enq_v;
        wr_ptr_d            = wr_ptr_q + 1'b1;
      end
      if (deq_fire) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (enq_fire && !deq_fire) begin
        count_d = count_q + 1'b1;
      end else if (deq_fire && !enq_fire) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) begin
        storage_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        storage_q[i] <= storage_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
